// File: rtl/pps_conditioner.sv
// pps_conditioner: synchronises and period-qualifies the raw GPS PPS, with holdover pulses when edges go missing.
// Optional build macro PPS_PERIOD_MEAS_EN: when defined, last_period and glitch_count are live; otherwise both read 0.
module pps_conditioner #(
    parameter int NOMINAL_PERIOD = 62500000,
    parameter int TOLERANCE      = 6250,
    parameter int PULSE_CYCLES   = 6250000,
    parameter int LOCK_COUNT     = 3,
    parameter int HOLDOVER_MAX   = 10,
    localparam int CW = $clog2(NOMINAL_PERIOD + TOLERANCE + 1)
) (
    input  logic          clk_62m5,
    input  logic          rst_n,
    input  logic          pps_in,
    output logic          one_pps,
    output logic          pps_locked,
    output logic          pps_holdover,
    output logic [CW-1:0] last_period,
    output logic [15:0]   glitch_count
);

    localparam int CW1    = CW + 1;
    localparam int WIN_LO = NOMINAL_PERIOD - TOLERANCE;
    localparam int WIN_HI = NOMINAL_PERIOD + TOLERANCE;
    localparam int WW     = $clog2(PULSE_CYCLES + 1);
    localparam int GW     = $clog2(LOCK_COUNT + 1);
    localparam int MW     = $clog2(HOLDOVER_MAX + 1);

    localparam logic [CW:0]   LO_C       = CW1'(WIN_LO);
    localparam logic [CW:0]   HI_C       = CW1'(WIN_HI);
    localparam logic [CW:0]   ONE_C      = CW1'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(WIN_HI);
    localparam logic [WW-1:0] PULSE_LAST = WW'(PULSE_CYCLES - 1);
    localparam logic [WW-1:0] WIDTH_ONE  = WW'(1);
    localparam logic [GW-1:0] LAST_GOOD  = GW'(LOCK_COUNT - 1);
    localparam logic [GW-1:0] GOOD_ONE   = GW'(1);
    localparam logic [MW-1:0] MISS_MAX_C = MW'(HOLDOVER_MAX);
    localparam logic [MW-1:0] MISS_ONE   = MW'(1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, HOLDOVER} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, sync2_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [WW-1:0] width_q, width_d;
    logic          one_pps_q, one_pps_d;
    logic          locked_q, locked_d;
    logic          holdover_q, holdover_d;

    logic          pps_edge, in_win, at_limit, synth_due, fire, drop;
    logic [CW:0]   cnt_inc;

    // cnt_inc is the distance from the previous accepted edge or synthetic pulse.
    assign pps_edge  = sync2_q & ~sync2_dly_q;
    assign cnt_inc   = {1'b0, cnt_q} + ONE_C;
    assign in_win    = (cnt_inc >= LO_C) && (cnt_inc <= HI_C);
    assign at_limit  = (cnt_inc == HI_C);
    assign synth_due = ({1'b0, period_q} == cnt_inc) && (miss_q < MISS_MAX_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CW-1:0];
        period_d  = period_q;
        good_d    = good_q;
        miss_d    = miss_q;
        fire      = 1'b0;
        drop      = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (pps_edge) begin
                    cnt_d   = '0;
                    good_d  = '0;
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (pps_edge) begin
                    cnt_d = '0;
                    if (in_win) begin
                        period_d = cnt_inc[CW-1:0];
                        if (good_q == LAST_GOOD) begin
                            good_d  = '0;
                            fire    = 1'b1;
                            state_d = LOCKED;
                        end else begin
                            good_d = good_q + GOOD_ONE;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (at_limit) begin
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                // At the limit cycle an edge is still in-window, so it beats the synthetic pulse.
                if (pps_edge && in_win) begin
                    fire     = 1'b1;
                    cnt_d    = '0;
                    period_d = cnt_inc[CW-1:0];
                end else if (at_limit) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    miss_d  = MISS_ONE;
                    state_d = HOLDOVER;
                end
            end
            HOLDOVER: begin
                if (pps_edge && in_win) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    miss_d  = '0;
                    state_d = LOCKED;
                end else if (synth_due) begin
                    fire   = 1'b1;
                    cnt_d  = '0;
                    miss_d = miss_q + MISS_ONE;
                end else if ((miss_q == MISS_MAX_C) && at_limit) begin
                    drop    = 1'b1;
                    miss_d  = '0;
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        locked_d   = (state_d == LOCKED) || (state_d == HOLDOVER);
        holdover_d = (state_d == HOLDOVER);
        one_pps_d  = one_pps_q;
        width_d    = width_q;
        // A new pulse reloads the width counter even if one_pps is already high.
        if (fire) begin
            one_pps_d = 1'b1;
            width_d   = PULSE_LAST;
        end else if (drop) begin
            one_pps_d = 1'b0;
            width_d   = '0;
        end else if (one_pps_q) begin
            if (width_q == '0) begin
                one_pps_d = 1'b0;
            end else begin
                width_d = width_q - WIDTH_ONE;
            end
        end
    end

    always_ff @(posedge clk_62m5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
            cnt_q       <= '0;
            period_q    <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            width_q     <= '0;
            one_pps_q   <= 1'b0;
            locked_q    <= 1'b0;
            holdover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= pps_in;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            width_q     <= width_d;
            one_pps_q   <= one_pps_d;
            locked_q    <= locked_d;
            holdover_q  <= holdover_d;
        end
    end

    assign one_pps      = one_pps_q;
    assign pps_locked   = locked_q;
    assign pps_holdover = holdover_q;

`ifdef PPS_PERIOD_MEAS_EN
    logic [15:0] glitch_q, glitch_d;
    logic        reject;

    // Any edge that is seen while tracking but falls outside the window is a glitch.
    assign reject = pps_edge && !in_win && (state_q != UNLOCKED);

    always_comb begin
        glitch_d = glitch_q;
        if (reject && (glitch_q != 16'hFFFF)) begin
            glitch_d = glitch_q + 16'd1;
        end
    end

    always_ff @(posedge clk_62m5 or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign last_period  = period_q;
    assign glitch_count = glitch_q;
`else
    assign last_period  = '0;
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_pps_conditioner.sv
// Scoreboard bench for pps_conditioner: directed PPS edges, expected one_pps pulses queued and checked by a monitor.
module tb_pps_conditioner;

    localparam int NOM   = 1000;
    localparam int TOL   = 10;
    localparam int PULSE = 100;
    localparam int LOCKN = 3;
    localparam int HMAX  = 4;
    localparam int CW    = $clog2(NOM + TOL + 1);

`ifdef PPS_PERIOD_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic          clk_62m5 = 1'b0;
    logic          rst_n    = 1'b1;
    logic          pps_in   = 1'b0;
    logic          one_pps;
    logic          pps_locked;
    logic          pps_holdover;
    logic [CW-1:0] last_period;
    logic [15:0]   glitch_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int expGlitch = 0;

    typedef struct {
        int   rise;
        logic locked;
        logic holdover;
    } exp_t;

    exp_t expQ[$];

    pps_conditioner #(
        .NOMINAL_PERIOD(NOM),
        .TOLERANCE(TOL),
        .PULSE_CYCLES(PULSE),
        .LOCK_COUNT(LOCKN),
        .HOLDOVER_MAX(HMAX)
    ) dut (
        .clk_62m5(clk_62m5),
        .rst_n(rst_n),
        .pps_in(pps_in),
        .one_pps(one_pps),
        .pps_locked(pps_locked),
        .pps_holdover(pps_holdover),
        .last_period(last_period),
        .glitch_count(glitch_count)
    );

    always #5 clk_62m5 = ~clk_62m5;

    // cyc counts rising edges; everything in the bench is sampled on the falling edge.
    always @(posedge clk_62m5) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Raise pps_in so that rising edge number 'at' is the first to sample it high.
    task automatic applyStimulus(input int at, input int width);
        while (cyc < at - 1) @(negedge clk_62m5);
        pps_in = 1'b1;
        repeat (width) @(negedge clk_62m5);
        pps_in = 1'b0;
    endtask

    task automatic expectPulse(input int rise, input logic locked, input logic holdover);
        exp_t e;
        e.rise     = rise;
        e.locked   = locked;
        e.holdover = holdover;
        expQ.push_back(e);
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) @(negedge clk_62m5);
    endtask

    function automatic logic [31:0] measVal(input int v);
        return MEAS ? 32'(v) : 32'd0;
    endfunction

    // Monitor: every one_pps rise pops one expectation; every fall outside reset checks the width.
    initial begin
        logic prevPps;
        int   highCnt;
        bit   tracking;
        exp_t e;
        prevPps  = 1'b0;
        highCnt  = 0;
        tracking = 1'b0;
        forever begin
            @(negedge clk_62m5);
            if (one_pps === 1'b1 && prevPps !== 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: one_pps rose at cycle %0d, required no pulse", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_cycle", 32'(cyc), 32'(e.rise));
                    checkOutput("pulse_locked", 32'(pps_locked), 32'(e.locked));
                    checkOutput("pulse_holdover", 32'(pps_holdover), 32'(e.holdover));
                end
                highCnt  = 1;
                tracking = 1'b1;
            end else if (one_pps === 1'b1) begin
                highCnt++;
            end else if (tracking) begin
                tracking = 1'b0;
                if (rst_n === 1'b1) checkOutput("pulse_width", 32'(highCnt), 32'(PULSE));
            end
            prevPps = one_pps;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_62m5);
        checkOutput("rst_one_pps", 32'(one_pps), 32'd0);
        checkOutput("rst_locked", 32'(pps_locked), 32'd0);
        checkOutput("rst_holdover", 32'(pps_holdover), 32'd0);
        checkOutput("rst_last_period", 32'(last_period), 32'd0);
        checkOutput("rst_glitch", 32'(glitch_count), 32'd0);
        rst_n = 1'b1;

        // Acquire: lock on the fourth edge spaced exactly one nominal period.
        applyStimulus(20, 5);
        applyStimulus(1020, 5);
        applyStimulus(2020, 5);
        waitCycle(2500);
        checkOutput("acq_not_locked", 32'(pps_locked), 32'd0);
        expectPulse(3022, 1'b1, 1'b0);
        applyStimulus(3020, 5);
        waitCycle(3030);
        checkOutput("acq_locked", 32'(pps_locked), 32'd1);
        checkOutput("acq_last_period", 32'(last_period), measVal(1000));

        // Upper tolerance boundary: 1010 accepted, 1011 too late so a synthetic pulse fires first.
        expectPulse(4032, 1'b1, 1'b0);
        applyStimulus(4030, 5);
        waitCycle(4100);
        checkOutput("tol_last_period", 32'(last_period), measVal(1010));
        expectPulse(5042, 1'b1, 1'b1);
        applyStimulus(5041, 5);
        expGlitch = 1;
        waitCycle(5100);
        checkOutput("tol_holdover", 32'(pps_holdover), 32'd1);
        checkOutput("tol_glitch", 32'(glitch_count), measVal(expGlitch));

        // Recovery: real edge at cnt 995 after the synthetic pulse.
        expectPulse(6038, 1'b1, 1'b0);
        applyStimulus(6036, 5);
        waitCycle(6100);
        checkOutput("rec_holdover", 32'(pps_holdover), 32'd0);
        checkOutput("rec_locked", 32'(pps_locked), 32'd1);
        checkOutput("rec_last_period", 32'(last_period), measVal(1010));

        // Glitch: short pulse 400 cycles in is ignored, the next nominal edge is accepted.
        applyStimulus(6436, 2);
        expGlitch = 2;
        waitCycle(6500);
        checkOutput("glitch_count", 32'(glitch_count), measVal(expGlitch));
        checkOutput("glitch_no_pulse", 32'(one_pps), 32'd0);
        expectPulse(7038, 1'b1, 1'b0);
        applyStimulus(7036, 5);
        waitCycle(7100);
        checkOutput("glitch_last_period", 32'(last_period), measVal(1000));

        // Holdover: no more edges, four synthetic pulses then lock is dropped.
        expectPulse(8048, 1'b1, 1'b1);
        expectPulse(9048, 1'b1, 1'b1);
        expectPulse(10048, 1'b1, 1'b1);
        expectPulse(11048, 1'b1, 1'b1);
        waitCycle(12050);
        checkOutput("hold_still_locked", 32'(pps_locked), 32'd1);
        checkOutput("hold_still_holdover", 32'(pps_holdover), 32'd1);
        waitCycle(12060);
        checkOutput("hold_dropped_locked", 32'(pps_locked), 32'd0);
        checkOutput("hold_dropped_holdover", 32'(pps_holdover), 32'd0);
        checkOutput("hold_dropped_pps", 32'(one_pps), 32'd0);

        // Relock after four fresh edges.
        applyStimulus(13000, 5);
        applyStimulus(14000, 5);
        applyStimulus(15000, 5);
        waitCycle(15500);
        checkOutput("relock_not_yet", 32'(pps_locked), 32'd0);
        expectPulse(16002, 1'b1, 1'b0);
        applyStimulus(16000, 5);

        // Reset in the 50th cycle of the pulse clears everything immediately.
        waitCycle(16051);
        checkOutput("pre_reset_pps", 32'(one_pps), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_one_pps", 32'(one_pps), 32'd0);
        checkOutput("midrst_locked", 32'(pps_locked), 32'd0);
        checkOutput("midrst_holdover", 32'(pps_holdover), 32'd0);
        checkOutput("midrst_glitch", 32'(glitch_count), 32'd0);
        checkOutput("midrst_last_period", 32'(last_period), 32'd0);
        repeat (3) @(negedge clk_62m5);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_62m5);
        checkOutput("pulses_outstanding", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
